vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Free-running VGA raster timing generator on the pixel clock (31.5 MHz, 640x480@72 Hz by default).
//  Sits directly upstream of the flappy_space renderer: supplies pixel position, active-video flag,
//  line/frame strobes and registered hsync/vsync that the renderer forwards to the pins.
//  All outputs are registered and mutually aligned: every output describes the same pixel in the same cycle.
// PARAMETERS
//  H_DISPLAY    640  active pixels per line
//  H_FRONT      24   horizontal front porch (pixels)
//  H_SYNC       40   horizontal sync width (pixels)
//  H_BACK       128  horizontal back porch (pixels)
//  V_DISPLAY    480  active lines per frame
//  V_FRONT      9    vertical front porch (lines)
//  V_SYNC       3    vertical sync width (lines)
//  V_BACK       28   vertical back porch (lines)
//  SYNC_ACTIVE  0    sync pulse level (0 = negative polarity); inactive level = ~SYNC_ACTIVE
//  POS_W        10   width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1      pixel clock
//  reset        in   1      asynchronous, active-high reset
//  hpos         out  POS_W  current column, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 832)
//  vpos         out  POS_W  current line, 0..V_TOTAL-1 (V_TOTAL = sum of V_* = 520)
//  display_on   out  1      1 when hpos<H_DISPLAY and vpos<V_DISPLAY
//  hsync        out  1      SYNC_ACTIVE when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC
//  vsync        out  1      SYNC_ACTIVE when V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC
//  line_start   out  1      1 for the single cycle where hpos==0
//  frame_start  out  1      1 for the single cycle where hpos==0 and vpos==0
// BEHAVIOUR
//  - Reset (async assert, sync release): hpos=H_TOTAL-1, vpos=V_TOTAL-1 (last pixel of frame);
//    display_on=0, hsync=vsync=~SYNC_ACTIVE, line_start=0, frame_start=0. Held while reset=1.
//  - First rising clk edge after reset release: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
//  - Each clk edge: hpos increments; at hpos==H_TOTAL-1 it wraps to 0 and vpos advances.
//  - vpos increments only on hpos wrap; at vpos==V_TOTAL-1 with hpos wrap, vpos wraps to 0 (new frame).
//  - Flag outputs are computed from the NEXT position and registered, so zero skew vs hpos/vpos;
//    no combinational path from any input to any output.
//  - Frame = 832*520 = 432640 cycles; line = 832 cycles; hsync low 40 cycles/line; vsync low 3 lines.
//  - Reset asserted mid-frame: outputs return to reset values immediately (async); timing restarts at
//    frame_start on first edge after release; no partial sync pulse is extended.
//  - Counter arithmetic is POS_W-bit unsigned; compares are exact equality at wrap points; counters
//    never reach H_TOTAL/V_TOTAL.
// TESTING
//  1. Hold reset 5 cycles -> hpos=831, vpos=519, display_on=0, hsync=vsync=1, strobes 0; release ->
//     next edge hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
//  2. Run 1 line from (0,0) -> display_on 1 for hpos 0..639, 0 at 640; hsync=0 exactly for hpos
//     664..703; line_start next high after 832 cycles with vpos=1.
//  3. Run full frame -> vsync=0 exactly for vpos 489..491 (3*832=2496 cycles); display_on=0 for all
//     vpos>=480; frame_start recurs every 432640 cycles; vpos max observed 519, hpos max 831.
//  4. Assert reset asynchronously at hpos=670, vpos=490 (both syncs active) -> hsync and vsync return
//     to 1 before next edge; after release sequence matches scenario 1.
//  5. Parameter override H_DISPLAY=8,H_FRONT=2,H_SYNC=2,H_BACK=2,V_*=4,1,1,1, SYNC_ACTIVE=1 ->
//     line period 14, hsync=1 for hpos 10..11, vsync=1 for vpos 5, frame period 98 cycles.
//  6. Checker every cycle: display_on, hsync, vsync, line_start, frame_start equal formulas of (hpos,vpos).

Source files
------------

// File: rtl/vga_sync_if.sv
// vga_sync_if: raster position and timing flags from vga_sync_gen to the renderer
//  hpos/vpos    current column/line
//  display_on   active-video flag
//  hsync/vsync  sync levels forwarded to the pins
//  line_start   first pixel of a line
//  frame_start  first pixel of a frame
interface vga_sync_if #(parameter int POS_W = 10);
   logic [POS_W-1:0] hpos;
   logic [POS_W-1:0] vpos;
   logic display_on;
   logic hsync;
   logic vsync;
   logic line_start;
   logic frame_start;
   modport master (output hpos, vpos, display_on, hsync, vsync, line_start, frame_start);
   modport slave (input hpos, vpos, display_on, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator on the pixel clock
//  clk    pixel clock
//  reset  asynchronous active-high reset, parks the raster on the last pixel of the frame
//  vga    master side of vga_sync_if: hpos, vpos, display_on, hsync, vsync, line_start, frame_start
module vga_sync_gen #(
   parameter int   H_DISPLAY   = 640,
   parameter int   H_FRONT     = 24,
   parameter int   H_SYNC      = 40,
   parameter int   H_BACK      = 128,
   parameter int   V_DISPLAY   = 480,
   parameter int   V_FRONT     = 9,
   parameter int   V_SYNC      = 3,
   parameter int   V_BACK      = 28,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   POS_W       = 10
) (
   input logic        clk,
   input logic        reset,
   vga_sync_if.master vga
);
   localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [POS_W-1:0] V_LAST  = POS_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [POS_W-1:0] H_ACT   = POS_W'(H_DISPLAY);
   localparam logic [POS_W-1:0] V_ACT   = POS_W'(V_DISPLAY);
   localparam logic [POS_W-1:0] HS_BEG  = POS_W'(H_DISPLAY + H_FRONT);
   localparam logic [POS_W-1:0] HS_LAST = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [POS_W-1:0] VS_BEG  = POS_W'(V_DISPLAY + V_FRONT);
   localparam logic [POS_W-1:0] VS_LAST = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   logic [POS_W-1:0] hpos, vpos, h_nxt, v_nxt;
   logic display_on, hsync, vsync, line_start, frame_start;
   always_comb begin
      h_nxt = (hpos == H_LAST) ? '0 : hpos + 1'b1;
      v_nxt = (hpos != H_LAST) ? vpos : (vpos == V_LAST) ? '0 : vpos + 1'b1;
   end
   // Flags are derived from the next position so they land in the same cycle as hpos/vpos.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hpos        <= H_LAST;
         vpos        <= V_LAST;
         display_on  <= 1'b0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hpos        <= h_nxt;
         vpos        <= v_nxt;
         display_on  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         hsync       <= (h_nxt >= HS_BEG && h_nxt <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= (v_nxt >= VS_BEG && v_nxt <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         line_start  <= (h_nxt == '0);
         frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end
   assign vga.hpos        = hpos;
   assign vga.vpos        = vpos;
   assign vga.display_on  = display_on;
   assign vga.hsync       = hsync;
   assign vga.vsync       = vsync;
   assign vga.line_start  = line_start;
   assign vga.frame_start = frame_start;
endmodule
